conv_ctrl_test: RTL and testbench

CONV_CTRL_TEST -- requirements
Module: conv_ctrl_test

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_line_buf.sv | 35 +++
 rtl/conv_ctrl_test.sv | 271 +++++++++++++++++++++++++++
 tb/tb_conv_ctrl_test.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the 3x3 convolution block.
//   DATA_W   : default pixel/weight/bias/result width
//   MAX_SIZE : default largest supported frame width/height
//   ACC_W    : accumulator width for the 9-term sum plus bias
//   PIPE_LAT : clock edges from accepting the window-completing pixel to po_data_valid
//   SIZE_W   : width of the image_size port and the row/column counters
package conv_pkg;

  localparam int DATA_W   = 16;
  localparam int MAX_SIZE = 511;
  localparam int ACC_W    = 36;
  localparam int PIPE_LAT = 3;
  localparam int SIZE_W   = 9;

  typedef logic signed [DATA_W-1:0]   data_t;
  typedef logic signed [2*DATA_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: one row of pixel storage, DEPTH x DATA_W RAM.
// One write and one registered read per cycle; no reset on the storage.
//   clk     : clock
//   wr_en   : write wr_data at wr_addr on this edge
//   wr_addr : write address (column)
//   wr_data : word to store
//   rd_addr : read address, captured on every edge
//   rd_data : word at the rd_addr presented on the previous edge
//             (read-before-write when addresses coincide)
module conv_line_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 511,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/conv_ctrl_test.sv
// conv_ctrl_test: streaming 3x3 valid convolution (stride 1, no padding)
// over square N x N frames in raster order, with saturating signed output.
//   sys_clk           : clock, all state on the rising edge
//   sys_rst           : asynchronous active-high reset, aborts any frame
//   image_size        : N, sampled when row=col=0 is accepted
//   pi_data           : signed input pixel, accepted when pi_data_valid=1
//   pi_data_valid     : input qualifier, no backpressure
//   weight1..weight9  : signed kernel, row-major, weight1 = top-left
//   bias              : signed offset added to every result
//   po_data           : saturated result, holds while po_data_valid=0
//   po_data_valid     : one-cycle result qualifier
//   frame_valid       : pulses with the last result of a frame
// Build option: define CONV_CTRL_RELU_EN to clamp negative results to 0.
module conv_ctrl_test #(
  parameter int DATA_W   = conv_pkg::DATA_W,
  parameter int MAX_SIZE = conv_pkg::MAX_SIZE
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [8:0]               image_size,
  input  logic signed [DATA_W-1:0] pi_data,
  input  logic                     pi_data_valid,
  input  logic signed [DATA_W-1:0] weight1,
  input  logic signed [DATA_W-1:0] weight2,
  input  logic signed [DATA_W-1:0] weight3,
  input  logic signed [DATA_W-1:0] weight4,
  input  logic signed [DATA_W-1:0] weight5,
  input  logic signed [DATA_W-1:0] weight6,
  input  logic signed [DATA_W-1:0] weight7,
  input  logic signed [DATA_W-1:0] weight8,
  input  logic signed [DATA_W-1:0] weight9,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] po_data,
  output logic                     po_data_valid,
  output logic                     frame_valid
);

  import conv_pkg::*;

  localparam int AW = $clog2(MAX_SIZE);
  localparam int SW = SIZE_W;

  typedef logic signed [DATA_W-1:0]   pix_t;
  typedef logic signed [2*DATA_W-1:0] mul_t;

  localparam acc_t SAT_HI = acc_t'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam acc_t SAT_LO = acc_t'(-(64'sd1 <<< (DATA_W - 1)));

  // ---------------------------------------------------------------------------
  // Raster position and frame size
  // ---------------------------------------------------------------------------
  logic          accept;
  logic [SW-1:0] col_q, col_d;
  logic [SW-1:0] row_q, row_d;
  logic [SW-1:0] size_q, size_d;
  logic [SW-1:0] n_eff;
  logic          n_ok;
  logic          col_last;
  logic          row_last;

  // Pixels presented during reset are not accepted, so the line-buffer read
  // address stays at column 0 across reset release.
  assign accept = pi_data_valid & ~sys_rst;

  always_comb begin
    // At the frame origin the live image_size is in force; otherwise the value
    // captured at the start of the frame.
    n_eff    = (row_q == '0 && col_q == '0) ? image_size : size_q;
    n_ok     = (n_eff >= SW'(3)) && (32'(n_eff) <= 32'(MAX_SIZE));
    col_last = (col_q == n_eff - SW'(1));
    row_last = (row_q == n_eff - SW'(1));

    col_d  = col_q;
    row_d  = row_q;
    size_d = size_q;
    if (accept) begin
      if (row_q == '0 && col_q == '0) begin
        size_d = image_size;
      end
      if (!n_ok) begin
        // Unsupported size: swallow the pixel and stay at the origin so the
        // next pixel resamples image_size.
        col_d = '0;
        row_d = '0;
      end else if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + SW'(1);
      end else begin
        col_d = col_q + SW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers
  // ---------------------------------------------------------------------------
  // The registered read is issued one cycle ahead at the next column, so the
  // words for the current column are already on rd_data when the pixel
  // arrives; the write lands at the current column on the accepting edge.
  logic [DATA_W-1:0] line1_rd;
  logic [DATA_W-1:0] line2_rd;

  conv_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_SIZE),
    .ADDR_W (AW)
  ) u_line1 (
    .clk     (sys_clk),
    .wr_en   (accept),
    .wr_addr (AW'(col_q)),
    .wr_data (pi_data),
    .rd_addr (AW'(col_d)),
    .rd_data (line1_rd)
  );

  conv_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_SIZE),
    .ADDR_W (AW)
  ) u_line2 (
    .clk     (sys_clk),
    .wr_en   (accept),
    .wr_addr (AW'(col_q)),
    .wr_data (line1_rd),
    .rd_addr (AW'(col_d)),
    .rd_data (line2_rd)
  );

  // ---------------------------------------------------------------------------
  // 3x3 window, flattened row-major: index 0 = top-left, 8 = bottom-right
  // ---------------------------------------------------------------------------
  pix_t win_q [9];
  pix_t win_d [9];
  logic win_vld_q, win_vld_d;
  logic win_last_q, win_last_d;

  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      win_d[k] = win_q[k];
    end
    if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[2] = pix_t'(line2_rd);
      win_d[5] = pix_t'(line1_rd);
      win_d[8] = pi_data;
    end
    win_vld_d  = accept && n_ok && (row_q >= SW'(2)) && (col_q >= SW'(2));
    win_last_d = win_vld_d && row_last && col_last;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: products (weights taken live in this cycle)
  // ---------------------------------------------------------------------------
  pix_t wgt [9];
  mul_t prod_q [9];
  mul_t prod_d [9];
  logic prod_vld_q, prod_vld_d;
  logic prod_last_q, prod_last_d;

  always_comb begin
    wgt[0] = weight1;
    wgt[1] = weight2;
    wgt[2] = weight3;
    wgt[3] = weight4;
    wgt[4] = weight5;
    wgt[5] = weight6;
    wgt[6] = weight7;
    wgt[7] = weight8;
    wgt[8] = weight9;
    for (int unsigned k = 0; k < 9; k++) begin
      prod_d[k] = mul_t'(win_q[k]) * mul_t'(wgt[k]);
    end
    prod_vld_d  = win_vld_q;
    prod_last_d = win_last_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: adder tree, wide enough that nine full-scale products never wrap
  // ---------------------------------------------------------------------------
  acc_t sum_q, sum_d;
  logic sum_vld_q, sum_vld_d;
  logic sum_last_q, sum_last_d;

  always_comb begin
    sum_d = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      sum_d = sum_d + acc_t'(prod_q[k]);
    end
    sum_vld_d  = prod_vld_q;
    sum_last_d = prod_last_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 3: bias, saturation, optional clamp
  // ---------------------------------------------------------------------------
  acc_t biased;
  pix_t res;
  pix_t po_data_q, po_data_d;
  logic po_vld_q, po_vld_d;
  logic frame_vld_q, frame_vld_d;

  always_comb begin
    biased = sum_q + acc_t'(bias);
    if (biased > SAT_HI) begin
      res = pix_t'(SAT_HI);
    end else if (biased < SAT_LO) begin
      res = pix_t'(SAT_LO);
    end else begin
      res = pix_t'(biased);
    end
`ifdef CONV_CTRL_RELU_EN
    if (res < 0) begin
      res = '0;
    end
`endif
    po_data_d   = sum_vld_q ? res : po_data_q;
    po_vld_d    = sum_vld_q;
    frame_vld_d = sum_vld_q && sum_last_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      col_q       <= '0;
      row_q       <= '0;
      size_q      <= '0;
      win_vld_q   <= 1'b0;
      win_last_q  <= 1'b0;
      prod_vld_q  <= 1'b0;
      prod_last_q <= 1'b0;
      sum_q       <= '0;
      sum_vld_q   <= 1'b0;
      sum_last_q  <= 1'b0;
      po_data_q   <= '0;
      po_vld_q    <= 1'b0;
      frame_vld_q <= 1'b0;
      for (int unsigned k = 0; k < 9; k++) begin
        win_q[k]  <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      size_q      <= size_d;
      win_vld_q   <= win_vld_d;
      win_last_q  <= win_last_d;
      prod_vld_q  <= prod_vld_d;
      prod_last_q <= prod_last_d;
      sum_q       <= sum_d;
      sum_vld_q   <= sum_vld_d;
      sum_last_q  <= sum_last_d;
      po_data_q   <= po_data_d;
      po_vld_q    <= po_vld_d;
      frame_vld_q <= frame_vld_d;
      for (int unsigned k = 0; k < 9; k++) begin
        win_q[k]  <= win_d[k];
        prod_q[k] <= prod_d[k];
      end
    end
  end

  assign po_data       = po_data_q;
  assign po_data_valid = po_vld_q;
  assign frame_valid   = frame_vld_q;

endmodule

// File: tb/tb_conv_ctrl_test.sv
// tb_conv_ctrl_test: directed and randomized frames for conv_ctrl_test,
// checked against a frame-level arithmetic model of the convolution.
module tb_conv_ctrl_test;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic [8:0]         image_size;
  logic signed [15:0] pi_data;
  logic               pi_data_valid;
  logic signed [15:0] wt [9];
  logic signed [15:0] bias_r;
  logic signed [15:0] po_data;
  logic               po_data_valid;
  logic               frame_valid;

  conv_ctrl_test #(
    .DATA_W   (16),
    .MAX_SIZE (511)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .image_size    (image_size),
    .pi_data       (pi_data),
    .pi_data_valid (pi_data_valid),
    .weight1       (wt[0]),
    .weight2       (wt[1]),
    .weight3       (wt[2]),
    .weight4       (wt[3]),
    .weight5       (wt[4]),
    .weight6       (wt[5]),
    .weight7       (wt[6]),
    .weight8       (wt[7]),
    .weight9       (wt[8]),
    .bias          (bias_r),
    .po_data       (po_data),
    .po_data_valid (po_data_valid),
    .frame_valid   (frame_valid)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    int fv;
    int cyc;
  } res_t;

  res_t obs_q[$];
  res_t exp_q[$];
  int   pix[$];
  int   acc[$];
  int   checks = 0;
  int   errors = 0;
  int   last_exp = 0;

  // Any cycle showing either qualifier is logged; stray frame_valid pulses
  // therefore show up as extra results.
  always @(negedge sys_clk) begin
    if (po_data_valid || frame_valid) begin
      obs_q.push_back('{int'(po_data), (po_data_valid && frame_valid) ? 1 : (frame_valid ? 2 : 0), cyc});
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: every 3x3 window fully inside the frame, in raster order.
  task automatic model_frame(input int n);
    longint s;
    for (int r = 2; r < n; r++) begin
      for (int c = 2; c < n; c++) begin
        s = longint'(bias_r);
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            s += longint'(wt[i*3 + j]) * longint'(pix[(r - 2 + i) * n + (c - 2 + j)]);
          end
        end
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef CONV_CTRL_RELU_EN
        if (s < 0) s = 0;
`endif
        exp_q.push_back('{int'(s), (r == n - 1 && c == n - 1) ? 1 : 0, acc[r * n + c] + 3});
      end
    end
  endtask

  // pmode: 0 ramp 1..n*n, 1 constant cval, 2 full-range random, 3 small random
  // gmode: 0 contiguous, 1 valid toggling 1,0, 2 random gaps + random image_size mid-frame
  task automatic send_frame(input int n, input int pmode, input int cval, input int gmode);
    logic signed [15:0] tmp;
    int g;
    pix.delete();
    acc.delete();
    for (int i = 0; i < n * n; i++) begin
      case (pmode)
        0: pix.push_back(i + 1);
        1: pix.push_back(cval);
        2: begin tmp = 16'($urandom); pix.push_back(int'(tmp)); end
        default: pix.push_back(int'($urandom_range(0, 200)) - 100);
      endcase
    end
    for (int i = 0; i < n * n; i++) begin
      @(negedge sys_clk);
      image_size    = (i != 0 && gmode == 2) ? 9'($urandom) : 9'(n);
      pi_data       = 16'(pix[i]);
      pi_data_valid = 1'b1;
      acc.push_back(cyc + 1);
      g = (gmode == 1) ? 1 : ((gmode == 2) ? int'($urandom_range(0, 2)) : 0);
      for (int k = 0; k < g; k++) begin
        @(negedge sys_clk);
        pi_data_valid = 1'b0;
        pi_data       = 16'($urandom);
      end
    end
    model_frame(n);
  endtask

  task automatic check_results(input string tag);
    int nmin;
    @(negedge sys_clk);
    pi_data_valid = 1'b0;
    repeat (8) @(negedge sys_clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
      chk($sformatf("%s_fv%0d", tag, i), obs_q[i].fv, exp_q[i].fv);
      chk($sformatf("%s_cyc%0d", tag, i), obs_q[i].cyc, exp_q[i].cyc);
    end
    if (exp_q.size() > 0) last_exp = exp_q[exp_q.size() - 1].data;
    chk({tag, "_hold"}, int'(po_data), last_exp);
    chk({tag, "_idle_vld"}, int'(po_data_valid), 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic set_weights(input int v, input int b);
    for (int k = 0; k < 9; k++) wt[k] = 16'(v);
    bias_r = 16'(b);
  endtask

  initial begin
    sys_rst       = 1'b1;
    image_size    = 9'd5;
    pi_data       = '0;
    pi_data_valid = 1'b0;
    set_weights(1, 0);

    repeat (3) @(negedge sys_clk);
    chk("rst_po_data", int'(po_data), 0);
    chk("rst_po_vld", int'(po_data_valid), 0);
    chk("rst_frame_vld", int'(frame_valid), 0);
    sys_rst = 1'b0;

    // Ramp frame, unit kernel: 63,72,81,108,117,126,153,162,171
    send_frame(5, 0, 0, 0);
    check_results("ramp");
    send_frame(5, 0, 0, 1);
    check_results("ramp_gap");

    set_weights(1, 5);
    send_frame(5, 1, 0, 0);
    check_results("zero_bias5");
    set_weights(1, 0);
    send_frame(5, 1, 32767, 0);
    check_results("sat_hi");
    send_frame(5, 1, -32768, 0);
    check_results("sat_lo");
    send_frame(5, 1, -3, 1);
    check_results("neg3");

    // Abort after 12 pixels: nothing has completed a window yet
    image_size = 9'd5;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      pi_data       = 16'(i + 1);
      pi_data_valid = 1'b1;
    end
    @(negedge sys_clk);
    pi_data_valid = 1'b0;
    sys_rst       = 1'b1;
    @(negedge sys_clk);
    chk("midrst_po_data", int'(po_data), 0);
    chk("midrst_po_vld", int'(po_data_valid), 0);
    chk("midrst_frame_vld", int'(frame_valid), 0);
    last_exp = 0;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("midrst_no_out", obs_q.size(), 0);
    obs_q.delete();
    send_frame(5, 0, 0, 0);
    check_results("after_rst");

    // Back-to-back frames with N changing at the boundary
    send_frame(5, 0, 0, 0);
    send_frame(4, 3, 0, 0);
    check_results("b2b");

    // Unsupported sizes consume pixels silently
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      image_size    = (i < 5) ? 9'd2 : 9'd0;
      pi_data       = 16'($urandom);
      pi_data_valid = 1'b1;
    end
    check_results("bad_n");

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      if (f % 2 == 0) begin
        for (int k = 0; k < 9; k++) wt[k] = 16'(int'($urandom_range(0, 16)) - 8);
        bias_r = 16'(int'($urandom_range(0, 2000)) - 1000);
      end else begin
        for (int k = 0; k < 9; k++) wt[k] = 16'($urandom);
        bias_r = 16'($urandom);
      end
      send_frame(int'($urandom_range(3, 8)), (f % 2 == 0) ? 3 : 2, 0, int'($urandom_range(0, 2)));
      check_results($sformatf("rand%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
